// File: rtl/mult_pkg.sv
// Shared types and constants for the round-robin shift-and-add multiplier sequencer.
package mult_pkg;

    // Default operand width; the product is twice this wide.
    localparam int unsigned MultWidth = 8;

    // Sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StAdd,
        StShift,
        StDone
    } state_e;

    // Index of one of the two requesters.
    typedef logic req_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select with a last-grant pointer.
// When update_i is high the pointer is taken as already advanced to grant_i,
// so a decision made in the same cycle as the update favours the other requester.
module rr_arbiter2
    import mult_pkg::*;
(
    input  logic       clock,
    input  logic       n_rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  req_idx_t   grant_i,
    output logic       valid_o,
    output req_idx_t   winner_o
);

    req_idx_t last_q;
    req_idx_t last_d;

    // Winner select: on contention pick the requester not granted last.
    always_comb begin
        last_d   = update_i ? grant_i : last_q;
        valid_o  = |req_i;
        winner_o = (req_i == 2'b11) ? ~last_d : req_i[1];
    end

    // Last-grant pointer; reset value makes requester 0 win first contention.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one shift-and-add multiplier datapath between two
// requesters. Grants the datapath, sequences WIDTH add/shift iterations and
// returns the 2*WIDTH product with a one-cycle done pulse.
// Optional: MULT_ZERO_BYPASS_EN skips the datapath when either operand is zero.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MultWidth
) (
    input  logic               clock,
    input  logic               n_rst,
    input  logic [1:0]         req,
    input  logic [WIDTH-1:0]   m0_in,
    input  logic [WIDTH-1:0]   q0_in,
    input  logic [WIDTH-1:0]   m1_in,
    input  logic [WIDTH-1:0]   q1_in,
    output logic [1:0]         ack,
    output logic [1:0]         done,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               dp_reset,
    output logic               dp_load_m,
    output logic               dp_add,
    output logic               dp_shift,
    output logic [WIDTH-1:0]   dp_m,
    output logic [WIDTH-1:0]   dp_q,
    input  logic               dp_q0,
    input  logic [2*WIDTH-1:0] dp_aq
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

`ifdef MULT_ZERO_BYPASS_EN
    localparam bit ZeroBypass = 1'b1;
`else
    localparam bit ZeroBypass = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    req_idx_t           winner_q, winner_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               arb_valid;
    req_idx_t           arb_winner;
    logic               arb_update;
    logic               take;

    logic [WIDTH-1:0]   win_m, win_q, cand_m, cand_q;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] post_shift;

    // A DONE cycle doubles as an arbitration cycle so a waiting request is
    // granted immediately after the result is returned.
    assign arb_update = (state_q == StDone);

    rr_arbiter2 u_rr_arbiter2 (
        .clock    (clock),
        .n_rst    (n_rst),
        .req_i    (req),
        .update_i (arb_update),
        .grant_i  (winner_q),
        .valid_o  (arb_valid),
        .winner_o (arb_winner)
    );

    // Operand muxes, carry prediction and the post-shift A:Q value. The last
    // shift lands in the datapath on the same edge the product is captured,
    // so the shifted value (with the final carry) is formed here.
    always_comb begin
        win_m      = winner_q ? m1_in : m0_in;
        win_q      = winner_q ? q1_in : q0_in;
        cand_m     = arb_winner ? m1_in : m0_in;
        cand_q     = arb_winner ? q1_in : q0_in;
        add_sum    = {1'b0, dp_aq[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
        post_shift = (2*WIDTH)'({carry_q, dp_aq} >> 1);
        cnt_inc    = cnt_q + CNT_W'(1);
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        winner_d  = winner_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        m_d       = m_q;
        product_d = product_q;
        take      = 1'b0;
        ack       = 2'b00;
        done      = 2'b00;
        dp_reset  = 1'b0;
        dp_load_m = 1'b0;
        dp_add    = 1'b0;
        dp_shift  = 1'b0;
        dp_m      = '0;
        dp_q      = '0;

        unique case (state_q)
            StIdle: begin
                take = arb_valid;
            end
            StLoad: begin
                ack[winner_q] = 1'b1;
                cnt_d         = '0;
                carry_d       = 1'b0;
                if (zero_q) begin
                    product_d = '0;
                    state_d   = StDone;
                end else begin
                    dp_reset  = 1'b1;
                    dp_load_m = 1'b1;
                    dp_m      = win_m;
                    dp_q      = win_q;
                    m_d       = win_m;
                    state_d   = StAdd;
                end
            end
            StAdd: begin
                dp_add  = dp_q0;
                carry_d = dp_q0 & add_sum[WIDTH];
                state_d = StShift;
            end
            StShift: begin
                dp_shift = 1'b1;
                cnt_d    = cnt_inc;
                if (cnt_inc < CNT_W'(WIDTH)) begin
                    state_d = StAdd;
                end else begin
                    product_d = post_shift;
                    state_d   = StDone;
                end
            end
            StDone: begin
                done[winner_q] = 1'b1;
                state_d        = StIdle;
                take           = arb_valid;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (take) begin
            winner_d = arb_winner;
            zero_d   = ZeroBypass && ((cand_m == '0) || (cand_q == '0));
            state_d  = StLoad;
        end
    end

    // State, counter and result registers.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            winner_q  <= 1'b0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            m_q       <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            winner_q  <= winner_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            m_q       <= m_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: a behavioural shift-and-add datapath, randomized
// requesters and a transaction-level reference model (product = m*q, fixed
// latency, round-robin order). Honors MULT_ZERO_BYPASS_EN like the design.
module tb_mult_arbiter;

    localparam int W   = 8;
    localparam int LAT = 2 * W + 1;
`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         n_rst;
    logic [1:0]   req;
    logic [W-1:0] m0_in, q0_in, m1_in, q1_in;
    logic [1:0]   ack, done;
    logic [2*W-1:0] product;
    logic         busy, dp_reset, dp_load_m, dp_add, dp_shift;
    logic [W-1:0] dp_m, dp_q;
    logic         dp_q0;
    logic [2*W-1:0] dp_aq;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mult_arbiter #(.WIDTH(W)) dut (
        .clock     (clock),
        .n_rst     (n_rst),
        .req       (req),
        .m0_in     (m0_in),
        .q0_in     (q0_in),
        .m1_in     (m1_in),
        .q1_in     (q1_in),
        .ack       (ack),
        .done      (done),
        .product   (product),
        .busy      (busy),
        .dp_reset  (dp_reset),
        .dp_load_m (dp_load_m),
        .dp_add    (dp_add),
        .dp_shift  (dp_shift),
        .dp_m      (dp_m),
        .dp_q      (dp_q),
        .dp_q0     (dp_q0),
        .dp_aq     (dp_aq)
    );

    // Behavioural datapath: C:A:Q plus M, driven by the dp_* controls.
    logic         c_r;
    logic [W-1:0] a_r, q_r, mreg_r;
    always @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            c_r <= 1'b0; a_r <= '0; q_r <= '0; mreg_r <= '0;
        end else begin
            if (dp_reset) begin
                c_r <= 1'b0; a_r <= '0; q_r <= dp_q;
            end
            if (dp_load_m) mreg_r <= dp_m;
            if (dp_add) {c_r, a_r} <= {1'b0, a_r} + {1'b0, mreg_r};
            if (dp_shift) begin
                c_r <= 1'b0;
                a_r <= {c_r, a_r[W-1:1]};
                q_r <= {a_r[0], q_r[W-1:1]};
            end
        end
    end
    assign dp_q0 = q_r[0];
    assign dp_aq = {a_r, q_r};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state (transaction level).
    logic       mon_en = 1'b0;
    int         cyc, done_cyc, add_cnt, shift_cnt;
    bit         active, free_prev, last, byp_job, owner;
    logic [1:0] req_prev, last_ack_exp;
    logic [W-1:0] om, oq;
    logic [2*W-1:0] exp_prod, prod_hold;

    task automatic monitor_cycle();
        logic [1:0] exp_ack, exp_done;
        bit win;
        if (!mon_en) begin
            cyc = 0; active = 0; free_prev = 1; last = 1; req_prev = 0;
            last_ack_exp = 0; prod_hold = 0; add_cnt = 0; shift_cnt = 0;
            return;
        end
        cyc++;
        exp_ack = 2'b00;
        win = 1'b0;
        if (free_prev && req_prev != 2'b00) begin
            win = (req_prev == 2'b11) ? ~last : req_prev[1];
            exp_ack[win] = 1'b1;
        end
        exp_done = 2'b00;
        if (active && cyc == done_cyc) exp_done[owner] = 1'b1;
        check("ack", ack, exp_ack);
        check("done", done, exp_done);
        if (exp_ack != 2'b00) begin
            owner    = win;
            om       = win ? m1_in : m0_in;
            oq       = win ? q1_in : q0_in;
            byp_job  = BYP && (om == 0 || oq == 0);
            done_cyc = cyc + (byp_job ? 1 : LAT);
            exp_prod = om * oq;
            add_cnt  = 0;
            shift_cnt = 0;
            active   = 1;
            check("load_ctl", {dp_reset, dp_load_m, dp_add, dp_shift},
                  byp_job ? 4'b0000 : 4'b1100);
            check("load_ops", {dp_m, dp_q}, byp_job ? 16'd0 : {om, oq});
        end else if (active) begin
            check("run_ctl", {dp_reset, dp_load_m, dp_add & dp_shift}, 3'b000);
            add_cnt   += int'(dp_add);
            shift_cnt += int'(dp_shift);
        end else begin
            check("idle_ctl", {dp_reset, dp_load_m, dp_add, dp_shift}, 4'b0000);
        end
        check("busy", busy, active);
        if (exp_done != 2'b00) begin
            check("product", product, exp_prod);
            check("add_count", add_cnt, byp_job ? 0 : $countones(oq));
            check("shift_count", shift_cnt, byp_job ? 0 : W);
            prod_hold = exp_prod;
            last = owner;
            active = 0;
        end else begin
            check("product_hold", product, prod_hold);
        end
        free_prev    = !active;
        req_prev     = req;
        last_ack_exp = exp_ack;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            monitor_cycle();
        end
    end

    // One cycle: inputs change 1 time unit after the rising edge; acked requests drop.
    task automatic step();
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) if (last_ack_exp[i]) req[i] = 1'b0;
    endtask

    task automatic raise(input int i, input logic [W-1:0] m, input logic [W-1:0] q);
        if (i == 0) begin m0_in = m; q0_in = q; end
        else begin m1_in = m; q1_in = q; end
        req[i] = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((req != 2'b00 || active) && n < 400) begin step(); n++; end
        check("drain_timeout", n < 400, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {ack, done, busy, dp_reset, dp_load_m, dp_add, dp_shift}, 0);
        check({tag, "_ops"}, {dp_m, dp_q}, 0);
        check({tag, "_product"}, product, 0);
    endtask

    initial begin
        int issued, n;
        n_rst = 1'b0; req = 2'b00;
        m0_in = '0; q0_in = '0; m1_in = '0; q1_in = '0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        step();
        n_rst = 1'b1; mon_en = 1'b1;

        // Abort a job with reset five cycles after its ack.
        raise(0, 8'd3, 8'd5);
        n = 0;
        while (req[0] && n < 100) begin step(); n++; end
        check("abort_ack_timeout", n < 100, 1);
        repeat (4) step();
        mon_en = 1'b0; n_rst = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) step();
        check("abort_no_done", {done, busy}, 0);
        n_rst = 1'b1; mon_en = 1'b1;

        // Contention straight out of reset: requester 0 first.
        raise(0, 8'd7, 8'd9);
        raise(1, 8'd6, 8'd5);
        drain();
        raise(0, 8'd3, 8'd4);
        drain();
        raise(0, 8'd13, 8'd11);
        drain();
        raise(1, 8'd255, 8'd255);
        drain();
        raise(0, 8'd0, 8'd200);
        drain();
        repeat (3) begin
            raise(0, W'($urandom), W'($urandom));
            raise(1, W'($urandom), W'($urandom));
            drain();
        end

        // Randomized traffic with biased operands.
        issued = 0;
        n = 0;
        while (issued < 60 && n < 6000) begin
            step();
            n++;
            for (int i = 0; i < 2; i++) begin
                if (!req[i] && !last_ack_exp[i] && issued < 60 && $urandom_range(0, 3) == 0) begin
                    logic [W-1:0] m, q;
                    m = W'($urandom);
                    q = W'($urandom);
                    case ($urandom_range(0, 7))
                        0: m = '0;
                        1: q = '0;
                        2: begin m = '1; q = '1; end
                        default: ;
                    endcase
                    raise(i, m, q);
                    issued++;
                end
            end
        end
        check("random_timeout", n < 6000, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one shift-and-add multiplier datapath (accumulator/Q register, M register, 8-bit adder) between two requesters.
- Grants the datapath round-robin and sequences the add/shift iterations itself, replacing the single-user sequencer for that datapath.
- Returns the 16-bit product to the granted requester with a one-cycle done pulse.
- Sits between the requesting blocks and the datapath inside the multiplier top level.

Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH; iteration count equals WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (localparam, derived).

Ports:
- clock  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- req  input  2  request per requester; held high with operands stable until ack.
- m0_in, q0_in  input  WIDTH each  multiplicand / multiplier, requester 0.
- m1_in, q1_in  input  WIDTH each  multiplicand / multiplier, requester 1.
- ack  output  2  one-cycle grant pulse; operands are taken on this cycle.
- done  output  2  one-cycle result-valid pulse to the granted requester.
- product  output  2*WIDTH  result register, valid when any done bit is high; holds until next result.
- busy  output  1  high from grant until done inclusive.
- dp_reset  output  1  datapath: clear A and C, load Q from dp_q.
- dp_load_m  output  1  datapath: load M from dp_m.
- dp_add  output  1  datapath: A <= A + M (carry into C).
- dp_shift  output  1  datapath: shift C:A:Q right by one.
- dp_m, dp_q  output  WIDTH each  operand mux to datapath; driven from the granted requester.
- dp_q0  input  1  datapath Q[0].
- dp_aq  input  2*WIDTH  datapath A:Q.

Behaviour:
- Reset (n_rst=0, asynchronous): state IDLE; ack=0; done=0; busy=0; all dp_* controls 0; dp_m=dp_q=0; product=0; iteration counter=0; round-robin pointer favours requester 0.
- Reset mid-operation aborts the job. No done is issued; the requester must re-request.
- States: IDLE, LOAD, ADD, SHIFT, DONE.
- IDLE:
  - if any req, select winner; go to LOAD.
  - both requesting: winner is the requester not granted last.
  - single request: that requester wins.
- LOAD (1 cycle): ack[winner]=1, dp_reset=1, dp_load_m=1, dp_m/dp_q = winner operands, busy=1, counter cleared; next ADD.
- ADD (1 cycle): dp_add = dp_q0; next SHIFT.
- SHIFT (1 cycle): dp_shift=1, counter+1; next ADD if counter < WIDTH after increment, else DONE.
- DONE (1 cycle): product <= dp_aq, registered on entry so it is valid alongside done. done[winner]=1; round-robin pointer updated to winner; next IDLE.
- Latency: ack cycle = T; done cycle = T + 2*WIDTH + 1 (T+17 for WIDTH=8); fixed, independent of operand values.
- Throughput: a waiting request is granted in the cycle after DONE, so the minimum spacing between acks is 2*WIDTH+2 cycles.
- req changes while not acked: ignored until IDLE evaluates it. Operands are only sampled in LOAD.
- req still high after ack: treated as a new request at the next IDLE. Requesters must drop req on ack.
- Only one dp_* control may be high at a time, except dp_reset+dp_load_m together in LOAD.
- Arithmetic: unsigned; product = m*q exactly, 0..(2^WIDTH-1)^2.

Optional Feature:
- Macro MULT_ZERO_BYPASS_EN.
- Defined: in IDLE, if the winner's m or q is 0, then
  - ack pulses, then next cycle done pulses with product=0 (LOAD->DONE path);
  - no dp_* control asserts;
  - latency is 1 cycle from ack to done;
  - round-robin pointer is updated as normal.
- Undefined: zero operands take the full 2*WIDTH+1 cycle sequence like any other.

Decomposition:
- Shared package mult_pkg holds:
  - the state enum (IDLE, LOAD, ADD, SHIFT, DONE);
  - the WIDTH default constant;
  - the requester-index typedef.
- One sub-module is natural: rr_arbiter2 (2-way round-robin winner select plus last-grant pointer). The FSM and counter stay in mult_arbiter.

Test Plan:
- Reset mid-job: assert n_rst=0 at ack+5 -> all outputs 0 immediately, no done; after release, re-request 3*4 -> done, product=12.
- Single requester: req=01, m0=13, q0=11 -> ack[0] at T, done[0] at T+17, product=143; dp_add high on exactly 3 ADD cycles (bits of 11).
- Max operands: req=10, m1=255, q1=255 -> done[1] at T+17, product=65025; carry path exercised.
- Contention: req=11 from reset with 7*9 and 6*5 -> req0 served first (63), then req1 acked the cycle after done[0], product=30; repeated contention alternates grants.
- Zero operand: m0=0, q0=200 -> product=0. Without MULT_ZERO_BYPASS_EN: done at T+17. With it: done at T+1 and no dp_* activity.
